// File: rtl/mult32x32_seq_unit.sv
// Sequential unsigned WIDTH x WIDTH multiplier, one 8x16 partial product per STEP cycle.
// Optional MULT_ZERO_SKIP_EN: a zero operand bypasses STEP and finishes in one cycle.
module mult32x32_seq_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic [WIDTH-1:0]               a,
   input  logic [WIDTH-1:0]               b,
   output logic                           busy,
   output logic                           valid,
   output logic [2*WIDTH-1:0]             product,
   output logic [$clog2(WIDTH/8)-1:0]     a_sel,
   output logic                           b_sel,
   output logic [$clog2(2*WIDTH)-1:0]     shift_val,
   output logic                           upd_prod,
   output logic                           clr_prod
);

   localparam int unsigned A_STEPS = WIDTH / 8;
   localparam int unsigned B_STEPS = WIDTH / 16;
   localparam int unsigned STEPS   = A_STEPS * B_STEPS;
   localparam int unsigned ASW     = $clog2(A_STEPS);
   localparam int unsigned CW      = ASW + 1;
   localparam int unsigned SHW     = $clog2(2 * WIDTH);
   localparam logic [CW-1:0] LAST  = CW'(STEPS - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_STEP = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;

   logic [ASW-1:0]     a_idx;
   logic               b_idx;
   logic [7:0]         a_byte;
   logic [15:0]        b_half;
   logic [23:0]        pp;
   logic [SHW-1:0]     shift_w;
   logic [2*WIDTH-1:0] pp_shifted;
   logic               in_step;

   assign a_idx      = cnt_q[ASW-1:0];
   assign b_idx      = cnt_q[CW-1];
   assign a_byte     = a_q[8*a_idx +: 8];
   assign b_half     = b_q[16*b_idx +: 16];
   assign pp         = {16'b0, a_byte} * {8'b0, b_half};
   assign shift_w    = SHW'(8 * int'(a_idx) + 16 * int'(b_idx));
   assign pp_shifted = {{(2*WIDTH-24){1'b0}}, pp} << shift_w;
   assign in_step    = (state_q == S_STEP);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      prod_d  = prod_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d    = a;
               b_d    = b;
               prod_d = '0;
               cnt_d  = '0;
`ifdef MULT_ZERO_SKIP_EN
               state_d = ((a == '0) || (b == '0)) ? S_DONE : S_STEP;
`else
               state_d = S_STEP;
`endif
            end
         end
         S_STEP: begin
            prod_d = prod_q + pp_shifted;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == LAST) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         prod_q  <= prod_d;
      end
   end

   // clr_prod is the only output fed by an input; gate it so reset forces it low too
   assign clr_prod  = (state_q == S_IDLE) && start && rst_n;
   assign busy      = (state_q == S_STEP) || (state_q == S_DONE);
   assign valid     = (state_q == S_DONE);
   assign upd_prod  = in_step;
   assign a_sel     = in_step ? a_idx : '0;
   assign b_sel     = in_step ? b_idx : 1'b0;
   assign shift_val = in_step ? shift_w : '0;
   assign product   = prod_q;

endmodule
